uart_rx: RTL

//  Serial UART receiver; the receive-side counterpart of uart_tx on the FPGA-to-host link.

---
 rtl/uart_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, fractional-accumulator oversample tick,
// start/stop framing check, one-cycle rx_valid / frame_err strobes.
module uart_rx #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_IN     = 40000000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int              CW        = $clog2(OVERSAMPLE);
  localparam logic [31:0]     INC       = 32'(BAUD_RATE * OVERSAMPLE);
  localparam logic [31:0]     CLK_LIM   = 32'(CLK_IN);
  localparam logic [CW-1:0]   CTR_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]   CTR_END   = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [31:0]          acc_q, acc_d;
  logic [CW-1:0]        ctr_q, ctr_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 err_q, err_d;
  logic                 armed_q, armed_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_busy_q, rx_busy_d;

  logic        rx_s;
  logic        tick;
  logic [31:0] acc_sum;
  logic        err_final;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], bit_in};
    acc_sum = acc_q + INC;
    tick    = (acc_sum >= CLK_LIM);
    acc_d   = tick ? (acc_sum - CLK_LIM) : acc_sum;
  end

  // NOTE: every _d is given its hold value before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    err_d       = err_q;
    armed_d     = armed_q;
    data_out_d  = data_out_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_busy_d   = rx_busy_q;
    err_final   = err_q | ~rx_s;

    unique case (state_q)
      IDLE: begin
        rx_busy_d = 1'b0;
        // After a framing error the line must be seen high before a new start is accepted.
        if (rx_s) armed_d = 1'b1;
        if (tick && armed_q && !rx_s) begin
          state_d   = START;
          ctr_d     = '0;
          err_d     = 1'b0;
          rx_busy_d = 1'b1;
        end
      end
      START: if (tick) begin
        if (ctr_q == CTR_MID) begin
          if (rx_s) begin
            state_d   = IDLE;
            rx_busy_d = 1'b0;
          end else begin
            state_d   = DATA;
            ctr_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (ctr_q == CTR_END) begin
          ctr_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            state_d    = STOP;
            stop_idx_d = 1'b0;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (ctr_q == CTR_END) begin
          ctr_d      = '0;
          err_d      = err_final;
          stop_idx_d = stop_idx_q + 1'b1;
          // Leave mid stop bit so a start edge straight after it is not missed.
          if (stop_idx_q == LAST_STOP) begin
            state_d   = IDLE;
            rx_busy_d = 1'b0;
            if (err_final) begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end else begin
              rx_valid_d = 1'b1;
              data_out_d = 8'(shift_q);
            end
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all flops are plain registers, so all are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      acc_q       <= '0;
      ctr_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      data_out_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      acc_q       <= acc_d;
      ctr_q       <= ctr_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      data_out_q  <= data_out_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  assign data_out  = data_out_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = rx_busy_q;

endmodule
